// File: rtl/cmprs_mb_scan_pkg.sv
// Shared compressor definitions: the macroblock scan FSM encoding, the
// converter-type codes, and a helper that gives the in-tile offset mask.
package cmprs_mb_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // Converter-type codes used by the tile-mode decoder upstream.
    localparam logic [2:0] CONV_COLOR18 = 3'd0;
    localparam logic [2:0] CONV_COLOR20 = 3'd1;
    localparam logic [2:0] CONV_MONO16  = 3'd2;
    localparam logic [2:0] CONV_JP4     = 3'd3;
    localparam logic [2:0] CONV_JP4DIFF = 3'd4;
    localparam logic [2:0] CONV_MONO8   = 3'd7;

    // Tile widths are 16 << code pixels, so the offset mask is that minus 1.
    function automatic logic [6:0] tile_offs_mask(input logic [1:0] tile_width);
        case (tile_width)
            2'd0:    return 7'h0f;
            2'd1:    return 7'h1f;
            2'd2:    return 7'h3f;
            default: return 7'h7f;
        endcase
    endfunction

endpackage

// File: rtl/cmprs_mb_scan.sv
// Macroblock scanner: walks a frame in raster order and hands one
// macroblock descriptor per accepted valid/ready transfer to the compressor.
module cmprs_mb_scan
    import cmprs_mb_scan_pkg::*;
#(
    parameter int FRAME_WIDTH_BITS = 13,
    parameter int PIX_BITS         = 16
) (
    input  logic                        xclk,
    input  logic                        xrst_n,
    input  logic                        frame_start,
    input  logic [FRAME_WIDTH_BITS-1:0] width_mb_m1,
    input  logic [FRAME_WIDTH_BITS-1:0] height_mb_m1,
    input  logic [5:0]                  mb_w_m1,
    input  logic [5:0]                  mb_h_m1,
    input  logic [4:0]                  mb_hper,
    input  logic [1:0]                  tile_width,
    output logic                        mb_valid,
    input  logic                        mb_ready,
    output logic [FRAME_WIDTH_BITS-1:0] mb_col,
    output logic [FRAME_WIDTH_BITS-1:0] mb_row,
    output logic [PIX_BITS-1:0]         mb_x,
    output logic [PIX_BITS-1:0]         mb_y,
    output logic [PIX_BITS-1:0]         mb_tile_col,
    output logic [6:0]                  mb_tile_offs,
    output logic [5:0]                  mb_size_w,
    output logic [5:0]                  mb_size_h,
    output logic                        mb_first,
    output logic                        mb_last_in_row,
    output logic                        mb_last,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    scan_state_t                 state, state_nxt;
    logic [FRAME_WIDTH_BITS-1:0] width_r, height_r;
    logic [FRAME_WIDTH_BITS-1:0] col_r, row_r;
    logic [PIX_BITS-1:0]         x_r, y_r;
    logic [4:0]                  hper_r;
    logic [1:0]                  tile_width_r;
    logic [5:0]                  size_w_r, size_h_r;
    logic                        overrun_r;
    logic                        last_col, last_row, accept;
    logic [2:0]                  tile_shift;

    assign last_col = (col_r == width_r);
    assign last_row = (row_r == height_r);
    assign accept   = mb_valid && mb_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge xclk or negedge xrst_n) begin
        if (!xrst_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        mb_valid  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_start) state_nxt = ST_LATCH;
            end
            ST_LATCH: state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                mb_valid = 1'b1;
                if (mb_ready && last_col && last_row) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Geometry latch at frame start, then raster advance on each accept.
    // Positions are accumulated with adders and wrap silently.
    always_ff @(posedge xclk or negedge xrst_n) begin
        if (!xrst_n) begin
            width_r      <= '0;
            height_r     <= '0;
            hper_r       <= '0;
            tile_width_r <= '0;
            size_w_r     <= '0;
            size_h_r     <= '0;
            col_r        <= '0;
            row_r        <= '0;
            x_r          <= '0;
            y_r          <= '0;
        end else if (state == ST_IDLE && frame_start) begin
            width_r      <= width_mb_m1;
            height_r     <= height_mb_m1;
            hper_r       <= mb_hper;
            tile_width_r <= tile_width;
            size_w_r     <= mb_w_m1;
            size_h_r     <= mb_h_m1;
            col_r        <= '0;
            row_r        <= '0;
            x_r          <= '0;
            y_r          <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_r <= '0;
                x_r   <= '0;
                row_r <= row_r + FRAME_WIDTH_BITS'(1);
                y_r   <= y_r + PIX_BITS'(hper_r);
            end else begin
                col_r <= col_r + FRAME_WIDTH_BITS'(1);
                x_r   <= x_r + PIX_BITS'(hper_r);
            end
        end
    end

    // One-cycle overrun flag for a frame_start that arrives mid-scan.
    always_ff @(posedge xclk or negedge xrst_n) begin
        if (!xrst_n) overrun_r <= 1'b0;
        else         overrun_r <= frame_start && (state != ST_IDLE);
    end

    assign overrun        = overrun_r;
    assign mb_col         = col_r;
    assign mb_row         = row_r;
    assign mb_x           = x_r;
    assign mb_y           = y_r;
    assign mb_size_w      = size_w_r;
    assign mb_size_h      = size_h_r;

    // Flags only qualify a live descriptor, so they read 0 when idle/reset.
    assign mb_first       = mb_valid && (col_r == '0) && (row_r == '0);
    assign mb_last_in_row = mb_valid && last_col;
    assign mb_last        = mb_last_in_row && last_row;

    assign tile_shift     = 3'd4 + {1'b0, tile_width_r};
    assign mb_tile_col    = x_r >> tile_shift;
    assign mb_tile_offs   = x_r[6:0] & tile_offs_mask(tile_width_r);

endmodule

// File: tb/tb_cmprs_mb_scan.sv
// Directed bench for the macroblock scanner.
module tb_cmprs_mb_scan;

    localparam int FW = 13;
    localparam int PB = 16;

    logic          xclk = 1'b0;
    logic          xrst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [FW-1:0] width_mb_m1 = '0;
    logic [FW-1:0] height_mb_m1 = '0;
    logic [5:0]    mb_w_m1 = '0;
    logic [5:0]    mb_h_m1 = '0;
    logic [4:0]    mb_hper = '0;
    logic [1:0]    tile_width = '0;
    logic          mb_ready = 1'b0;
    logic          mb_valid;
    logic [FW-1:0] mb_col, mb_row;
    logic [PB-1:0] mb_x, mb_y, mb_tile_col;
    logic [6:0]    mb_tile_offs;
    logic [5:0]    mb_size_w, mb_size_h;
    logic          mb_first, mb_last_in_row, mb_last;
    logic          busy, done, overrun;

    int errors = 0;
    int checks = 0;

    cmprs_mb_scan #(.FRAME_WIDTH_BITS(FW), .PIX_BITS(PB)) dut (
        .xclk(xclk), .xrst_n(xrst_n), .frame_start(frame_start),
        .width_mb_m1(width_mb_m1), .height_mb_m1(height_mb_m1),
        .mb_w_m1(mb_w_m1), .mb_h_m1(mb_h_m1), .mb_hper(mb_hper),
        .tile_width(tile_width), .mb_valid(mb_valid), .mb_ready(mb_ready),
        .mb_col(mb_col), .mb_row(mb_row), .mb_x(mb_x), .mb_y(mb_y),
        .mb_tile_col(mb_tile_col), .mb_tile_offs(mb_tile_offs),
        .mb_size_w(mb_size_w), .mb_size_h(mb_size_h),
        .mb_first(mb_first), .mb_last_in_row(mb_last_in_row), .mb_last(mb_last),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 xclk = ~xclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge xclk);
        #1;
    endtask

    task automatic set_geom(input int w, input int h, input int sw, input int sh,
                            input int hper, input int tw);
        width_mb_m1  = FW'(w);
        height_mb_m1 = FW'(h);
        mb_w_m1      = 6'(sw);
        mb_h_m1      = 6'(sh);
        mb_hper      = 5'(hper);
        tile_width   = 2'(tw);
    endtask

    // Pulse frame_start and return in the first ISSUE cycle.
    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"},  mb_valid, 0);
        check({tag, ".done"},   done, 0);
        check({tag, ".ovr"},    overrun, 0);
        check({tag, ".busy"},   busy, 0);
        check({tag, ".col"},    mb_col, 0);
        check({tag, ".row"},    mb_row, 0);
        check({tag, ".x"},      mb_x, 0);
        check({tag, ".y"},      mb_y, 0);
        check({tag, ".tcol"},   mb_tile_col, 0);
        check({tag, ".toffs"},  mb_tile_offs, 0);
        check({tag, ".sw"},     mb_size_w, 0);
        check({tag, ".sh"},     mb_size_h, 0);
        check({tag, ".first"},  mb_first, 0);
        check({tag, ".lir"},    mb_last_in_row, 0);
        check({tag, ".last"},   mb_last, 0);
    endtask

    initial begin
        int ex_x[6]    = '{0, 16, 32, 0, 16, 32};
        int ex_y[6]    = '{0, 0, 0, 16, 16, 16};
        int ex_tcol[6] = '{0, 0, 1, 0, 0, 1};
        int ex_offs[6] = '{0, 16, 0, 0, 16, 0};
        logic [31:0] ready_pat;
        int mcol, mrow, n_acc, seen_done;
        logic stalled, acc;
        logic [FW-1:0] pcol, prow;
        logic [PB-1:0] px, py;

        // ---- reset state ----
        step();
        step();
        check_zero("rst");
        xrst_n = 1'b1;
        step();
        check("idle.busy", busy, 0);

        // ---- COLOR18 3x2 frame, ready held high ----
        set_geom(2, 1, 17, 17, 16, 1);
        mb_ready    = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("c18.latch.busy", busy, 1);
        check("c18.latch.valid", mb_valid, 0);
        // Geometry changes after the latch must not affect this frame.
        set_geom(5, 4, 3, 3, 8, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            check("c18.valid", mb_valid, 1);
            check("c18.x", mb_x, ex_x[i]);
            check("c18.y", mb_y, ex_y[i]);
            check("c18.col", mb_col, i % 3);
            check("c18.row", mb_row, i / 3);
            check("c18.tcol", mb_tile_col, ex_tcol[i]);
            check("c18.toffs", mb_tile_offs, ex_offs[i]);
            check("c18.first", mb_first, (i == 0) ? 1 : 0);
            check("c18.lir", mb_last_in_row, (i % 3 == 2) ? 1 : 0);
            check("c18.last", mb_last, (i == 5) ? 1 : 0);
            check("c18.sw", mb_size_w, 17);
            step();
        end
        check("c18.end.valid", mb_valid, 0);
        check("c18.end.done", done, 1);
        check("c18.end.busy", busy, 1);
        step();
        check("c18.idle.done", done, 0);
        check("c18.idle.busy", busy, 0);

        // ---- MONO8, 20 columns, 128-pixel tiles ----
        set_geom(19, 0, 7, 7, 8, 3);
        start_frame();
        for (int i = 0; i < 20; i++) begin
            check("m8.x", mb_x, i * 8);
            if (i == 10) begin
                check("m8.c10.tcol", mb_tile_col, 0);
                check("m8.c10.toffs", mb_tile_offs, 80);
            end
            if (i == 19) begin
                check("m8.c19.col", mb_col, 19);
                check("m8.c19.x", mb_x, 152);
                check("m8.c19.tcol", mb_tile_col, 1);
                check("m8.c19.toffs", mb_tile_offs, 24);
                check("m8.c19.last", mb_last, 1);
            end
            step();
        end
        check("m8.done", done, 1);
        step();

        // ---- 3x3 frame with irregular ready and a mid-scan frame_start ----
        set_geom(2, 2, 15, 15, 16, 0);
        ready_pat = 32'b0110_1101_0011_1010_1100_0111_0101_1001;
        mcol = 0; mrow = 0; n_acc = 0; seen_done = 0; stalled = 1'b0;
        pcol = '0; prow = '0; px = '0; py = '0;
        start_frame();
        for (int cyc = 0; cyc < 200; cyc++) begin
            mb_ready    = ready_pat[cyc % 32];
            frame_start = (cyc == 4);
            if (cyc == 5) check("ovr.pulse", overrun, 1);
            if (cyc == 6) check("ovr.clear", overrun, 0);
            if (done) begin
                seen_done = 1;
                break;
            end
            acc = 1'b0;
            if (mb_valid) begin
                if (stalled) begin
                    check("rnd.hold.col", mb_col, pcol);
                    check("rnd.hold.row", mb_row, prow);
                    check("rnd.hold.x", mb_x, px);
                    check("rnd.hold.y", mb_y, py);
                end
                check("rnd.col", mb_col, mcol);
                check("rnd.row", mb_row, mrow);
                check("rnd.x", mb_x, mcol * 16);
                check("rnd.y", mb_y, mrow * 16);
                check("rnd.tcol", mb_tile_col, mcol);
                pcol = mb_col; prow = mb_row; px = mb_x; py = mb_y;
                acc = mb_ready;
                stalled = !mb_ready;
            end
            step();
            if (acc) begin
                n_acc++;
                if (mcol == 2) begin
                    mcol = 0;
                    mrow++;
                end else begin
                    mcol++;
                end
            end
        end
        frame_start = 1'b0;
        check("rnd.done_seen", seen_done, 1);
        check("rnd.accepts", n_acc, 9);
        step();

        // ---- asynchronous reset after the third accept ----
        set_geom(2, 1, 17, 19, 16, 1);
        mb_ready = 1'b1;
        start_frame();
        step();
        step();
        step();
        #2;
        xrst_n = 1'b0;
        #1;
        check_zero("arst");
        step();
        xrst_n = 1'b1;
        step();
        step();
        check("arst.norestart.valid", mb_valid, 0);
        check("arst.norestart.busy", busy, 0);
        start_frame();
        check("arst.new.valid", mb_valid, 1);
        check("arst.new.col", mb_col, 0);
        check("arst.new.row", mb_row, 0);
        check("arst.new.first", mb_first, 1);
        check("arst.new.sh", mb_size_h, 19);
        for (int i = 0; i < 6; i++) step();
        check("arst.new.done", done, 1);
        step();

        // ---- 1x1 frame ----
        set_geom(0, 0, 7, 7, 8, 3);
        start_frame();
        check("one.valid", mb_valid, 1);
        check("one.first", mb_first, 1);
        check("one.lir", mb_last_in_row, 1);
        check("one.last", mb_last, 1);
        step();
        check("one.end.valid", mb_valid, 0);
        check("one.end.done", done, 1);
        step();
        check("one.idle.done", done, 0);
        check("one.idle.busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmprs_mb_scan.md
CMPRS_MB_SCAN -- requirements
Module: cmprs_mb_scan

Interface
REQ-001 Parameter FRAME_WIDTH_BITS, default 13, width of macroblock column/row counts.
REQ-002 Parameter PIX_BITS, default 16, width of pixel-coordinate outputs.
REQ-003 xclk  input  1  compressor clock; all logic on rising edge.
REQ-004 xrst_n  input  1  reset, asynchronous, active-low.
REQ-005 frame_start  input  1  one-cycle pulse that starts a frame scan.
REQ-006 width_mb_m1  input  FRAME_WIDTH_BITS  frame width in macroblocks minus 1.
REQ-007 height_mb_m1  input  FRAME_WIDTH_BITS  frame height in macroblocks minus 1.
REQ-008 mb_w_m1, mb_h_m1  input  6 each  macroblock width/height minus 1 (17/19/15/7), from the tile-mode decoder.
REQ-009 mb_hper  input  5  macroblock period in pixels (16 or 8).
REQ-010 tile_width  input  2  memory tile width code: 0=16, 1=32, 2=64, 3=128 pixels.
REQ-011 mb_valid  output  1  macroblock descriptor valid.
REQ-012 mb_ready  input  1  downstream accepts the descriptor.
REQ-013 mb_col, mb_row  output  FRAME_WIDTH_BITS each  macroblock indices.
REQ-014 mb_x, mb_y  output  PIX_BITS each  top-left pixel of the macroblock.
REQ-015 mb_tile_col  output  PIX_BITS  memory tile column index = mb_x >> (4+tile_width).
REQ-016 mb_tile_offs  output  7  mb_x modulo tile width in pixels.
REQ-017 mb_size_w, mb_size_h  output  6 each  latched mb_w_m1/mb_h_m1.
REQ-018 mb_first, mb_last_in_row, mb_last  output  1 each  flags that qualify the current descriptor.
REQ-019 busy  output  1  scan in progress; done  output  1  one-cycle end-of-frame pulse.
REQ-020 overrun  output  1  one-cycle pulse when frame_start is received while busy.

Function
REQ-021 FSM states: IDLE, LATCH, ISSUE, DONE.
REQ-022 IDLE + frame_start -> LATCH; latch all geometry inputs into internal registers; clear col/row/x/y to 0.
REQ-023 LATCH -> ISSUE after one cycle; mb_valid rises 2 cycles after the frame_start pulse.
REQ-024 In ISSUE, mb_valid=1; all descriptor outputs stay stable until mb_valid && mb_ready.
REQ-025 On accept, if not last in row: col+1, mb_x += mb_hper.
REQ-026 On accept at the last column: col=0, mb_x=0, row+1, mb_y += mb_hper.
REQ-027 On accept of the final macroblock (col==width_mb_m1, row==height_mb_m1): -> DONE, mb_valid=0 in the next cycle.
REQ-028 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-029 Back-to-back transfers are required: with mb_ready held high, one descriptor is accepted per cycle.
REQ-030 mb_first=1 only at col=0,row=0; mb_last_in_row=(col==width_mb_m1); mb_last=mb_last_in_row && (row==height_mb_m1).
REQ-031 mb_x and mb_y are built with adders, not multipliers, and wrap modulo 2^PIX_BITS; the team does not guard against overflow.
REQ-032 mb_tile_col and mb_tile_offs are combinational from registered mb_x and the latched tile_width.
REQ-033 frame_start in any state other than IDLE is ignored and pulses overrun; the scan continues unaffected.
REQ-034 Geometry input changes after LATCH have no effect until the next frame.
REQ-035 width_mb_m1=0 and height_mb_m1=0 yields exactly one descriptor with mb_first=mb_last=1.
REQ-036 busy=1 in LATCH, ISSUE and DONE.

Reset
REQ-037 Asserting xrst_n low forces IDLE immediately, at any time including mid-scan.
REQ-038 On reset, all outputs are 0: mb_valid, done, overrun, busy, indices, coordinates, sizes and flags.
REQ-039 After reset release, the block waits for a fresh frame_start; no partial scan resumes.

Structure
REQ-040 The FSM state encoding and the converter-type constants (COLOR18=0, COLOR20=1, MONO16=2, JP4=3, JP4DIFF=4, MONO8=7) belong in the shared compressor package.
REQ-041 Single module; the existing tile-mode decoder is instantiated by the parent, not inside this block.

Verification
REQ-042 COLOR18 (hper=16, tile_width=1), width_mb_m1=2, height_mb_m1=1, mb_ready=1 -> 6 descriptors on consecutive cycles with mb_x=0,16,32,0,16,32 and mb_y=0,0,0,16,16,16; mb_tile_col=0,0,1,...; done 1 cycle after the 6th accept.
REQ-043 MONO8 (hper=8, tile_width=3), width_mb_m1=19 -> mb_x=152 at col 19, mb_tile_col=1, mb_tile_offs=24.
REQ-044 mb_ready toggled randomly -> descriptor outputs are stable while mb_valid && !mb_ready; no descriptor is lost or duplicated.
REQ-045 frame_start pulsed mid-scan -> overrun pulse; descriptor sequence unchanged.
REQ-046 xrst_n asserted after the 3rd accept -> all outputs 0 asynchronously; a new frame_start restarts at col=0,row=0 with mb_first=1.
REQ-047 1x1 frame -> a single descriptor with mb_first=mb_last=mb_last_in_row=1, then done.
